// File: rtl/conv_window_fetch_ctrl_pkg.sv
// cnn_mem_pkg: shared types and bus defaults for the convolution fetch path and memory arbiter
//   fetch_state_t : sequencer states
//   DEF_*         : default bus/dimension widths shared with the arbiter
//   KERNEL_K      : default kernel side
//   cnt_width()   : counter width for values 0..n-1, never zero
package cnn_mem_pkg;
    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DIM_WIDTH  = 8;
    localparam int KERNEL_K       = 3;
    typedef enum logic [2:0] {IDLE, FETCH, GAP, PRESENT, DONE} fetch_state_t;
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/conv_window_fetch_ctrl_if.sv
// conv_window_fetch_ctrl_if: single arbiter port, one outstanding request (sel/w/ready handshake)
//   sel   : request held until ready
//   w     : write enable
//   addr  : word address, stable while sel is high
//   rdata : read data, valid in the ready cycle
//   ready : request serviced this cycle
interface conv_window_fetch_ctrl_if import cnn_mem_pkg::*; #(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  sel;
    logic                  w;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ready;
    modport master (output sel, w, addr, input rdata, ready);
    modport slave  (input sel, w, addr, output rdata, ready);
endinterface

// File: rtl/conv_window_fetch_ctrl_addr_gen.sv
// window_addr_gen: window origin and in-window offset counters plus word address computation
//   clear    : restart scan at window (0,0), offset (0,0)
//   step_k   : advance offset, kc fastest, wrapping to (0,0) after the last slot
//   step_win : advance window origin in raster order
//   addr     : base + (row+kr)*img_w + (col+kc), modulo 2^ADDR_WIDTH
//   slot     : kr*K+kc
//   k_zero   : offset is (0,0)
//   last_win : origin is the final window
module window_addr_gen import cnn_mem_pkg::*; #(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DIM_WIDTH  = DEF_DIM_WIDTH,
    parameter int K          = KERNEL_K,
    parameter int SW         = cnt_width(K * K)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  step_k,
    input  logic                  step_win,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [DIM_WIDTH-1:0]  img_w,
    input  logic [DIM_WIDTH-1:0]  img_h,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [SW-1:0]         slot,
    output logic [DIM_WIDTH-1:0]  row,
    output logic [DIM_WIDTH-1:0]  col,
    output logic                  k_zero,
    output logic                  last_win
);
    localparam int KW = cnt_width(K);
    logic [KW-1:0] kr, kc;
    logic last_col, last_row, last_kc, last_kr;
    assign last_col = col == img_w - DIM_WIDTH'(K);
    assign last_row = row == img_h - DIM_WIDTH'(K);
    assign last_kc  = kc == KW'(K - 1);
    assign last_kr  = kr == KW'(K - 1);
    assign last_win = last_col && last_row;
    assign k_zero   = kr == '0 && kc == '0;
    assign slot     = SW'(kr) * SW'(K) + SW'(kc);
    assign addr     = base + (ADDR_WIDTH'(row) + ADDR_WIDTH'(kr)) * ADDR_WIDTH'(img_w)
                    + ADDR_WIDTH'(col) + ADDR_WIDTH'(kc);
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            row <= '0;
            col <= '0;
            kr  <= '0;
            kc  <= '0;
        end else begin
            if (step_k) begin
                kc <= last_kc ? '0 : kc + 1'b1;
                kr <= last_kc ? (last_kr ? '0 : kr + 1'b1) : kr;
            end
            if (step_win) begin
                col <= last_col ? '0 : col + 1'b1;
                row <= last_col ? row + 1'b1 : row;
            end
        end
    end
endmodule

// File: rtl/conv_window_fetch_ctrl.sv
// conv_window_fetch_ctrl: walks a KxK window over a row-major image, fetching each window word by word
//   clk, rst                  : clock, synchronous active-high reset
//   start                     : latch base_addr/img_w/img_h and begin scan (ignored while busy)
//   busy, done                : scan in progress, one-cycle completion pulse
//   mem                       : read-only arbiter port
//   win_data/win_row/win_col  : packed window and its output position
//   win_valid, win_ready      : window handshake to the PE array
module conv_window_fetch_ctrl import cnn_mem_pkg::*; #(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int K          = KERNEL_K,
    parameter int DIM_WIDTH  = DEF_DIM_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [DIM_WIDTH-1:0]    img_w,
    input  logic [DIM_WIDTH-1:0]    img_h,
    output logic                    busy,
    output logic                    done,
    conv_window_fetch_ctrl_if.master mem,
    output logic [K*K*DATA_WIDTH-1:0] win_data,
    output logic [DIM_WIDTH-1:0]    win_row,
    output logic [DIM_WIDTH-1:0]    win_col,
    output logic                    win_valid,
    input  logic                    win_ready
);
    localparam int SW = cnt_width(K * K);
    fetch_state_t state, state_nx;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [DIM_WIDTH-1:0]  w_q, h_q;
    logic [DATA_WIDTH-1:0] slots [K*K];
    logic [SW-1:0]         slot;
    logic go, too_small, fire, accept, k_zero, last_win;
    assign go        = state == IDLE && start;
    assign too_small = img_w < DIM_WIDTH'(K) || img_h < DIM_WIDTH'(K);
    assign fire      = state == FETCH && mem.ready;
    assign accept    = state == PRESENT && win_ready;
    window_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DIM_WIDTH (DIM_WIDTH),
        .K         (K),
        .SW        (SW)
    ) u_addr (
        .clk     (clk),
        .rst     (rst),
        .clear   (go),
        .step_k  (fire),
        .step_win(accept),
        .base    (base_q),
        .img_w   (w_q),
        .img_h   (h_q),
        .addr    (mem.addr),
        .slot    (slot),
        .row     (win_row),
        .col     (win_col),
        .k_zero  (k_zero),
        .last_win(last_win)
    );
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // GAP follows every capture; offset back at (0,0) there means the last slot was just filled
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = too_small ? DONE : FETCH;
            FETCH:   if (mem.ready) state_nx = GAP;
            GAP:     state_nx = k_zero ? PRESENT : FETCH;
            PRESENT: if (win_ready) state_nx = last_win ? DONE : FETCH;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        busy      = state != IDLE;
        done      = state == DONE;
        mem.sel   = state == FETCH;
        mem.w     = 1'b0;
        win_valid = state == PRESENT;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q <= '0;
            w_q    <= '0;
            h_q    <= '0;
        end else if (go) begin
            base_q <= base_addr;
            w_q    <= img_w;
            h_q    <= img_h;
        end
    end
    always_ff @(posedge clk) begin
        if (rst)       slots <= '{default: '0};
        else if (fire) slots[slot] <= mem.rdata;
    end
    for (genvar i = 0; i < K * K; i++) begin : g_pack
        assign win_data[i*DATA_WIDTH +: DATA_WIDTH] = slots[i];
    end
endmodule

// File: tb/tb_conv_window_fetch_ctrl.sv
// tb_conv_window_fetch_ctrl: scoreboard bench for the window fetch sequencer with a latency-programmable memory model
module tb_conv_window_fetch_ctrl;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int K  = 3;
    localparam int NW = K * K;

    typedef struct {
        logic [NW*DW-1:0] data;
        logic [7:0]       row;
        logic [7:0]       col;
    } win_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [7:0] img_w = '0, img_h = '0;
    logic busy, done, win_valid;
    logic win_ready = 1'b1;
    logic [NW*DW-1:0] win_data;
    logic [7:0] win_row, win_col;

    int vectors = 0, errors = 0;
    int lat = 0;
    bit spur = 1'b0;
    int done_cnt = 0, sel_cnt = 0, win_cnt = 0;
    int wait_cnt = 0, gap_cnt = 0;
    logic prev_sel = 1'b0, prev_rdy = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    win_t exp_win[$];
    logic [AW-1:0] exp_addr[$];
    logic [AW-1:0] obs_addr[$];

    conv_window_fetch_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_bus ();

    conv_window_fetch_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .K(K), .DIM_WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_addr(base_addr),
        .img_w    (img_w),
        .img_h    (img_h),
        .busy     (busy),
        .done     (done),
        .mem      (mem_bus),
        .win_data (win_data),
        .win_row  (win_row),
        .win_col  (win_col),
        .win_valid(win_valid),
        .win_ready(win_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pix(input logic [AW-1:0] a);
        return {a ^ 16'hC3A5, a + 16'h1234};
    endfunction

    // memory responder and protocol/scoreboard monitor, 1 time unit after each falling edge
    always @(negedge clk) begin
        logic rdy;
        logic [DW-1:0] rd;
        logic [AW-1:0] ea;
        win_t ew;
        #1;
        rdy = 1'b0;
        rd = '0;
        if (mem_bus.sel) begin
            sel_cnt++;
            vectors++;
            if (mem_bus.w !== 1'b0) begin
                errors++;
                $display("FAIL mem_w: got %b want 0", mem_bus.w);
            end
            vectors++;
            if (prev_sel && prev_rdy) begin
                errors++;
                $display("FAIL gap_missing: sel %b after ready, want 0", mem_bus.sel);
            end else if (prev_sel && mem_bus.addr !== prev_addr) begin
                errors++;
                $display("FAIL addr_hold: got %h want %h", mem_bus.addr, prev_addr);
            end
            vectors++;
            if (gap_cnt > 1) begin
                errors++;
                $display("FAIL gap_len: got %0d cycles want 1", gap_cnt);
            end
            gap_cnt = 0;
            if (wait_cnt >= lat) begin
                rdy = 1'b1;
                rd = pix(mem_bus.addr);
                wait_cnt = 0;
                obs_addr.push_back(mem_bus.addr);
                vectors++;
                if (exp_addr.size() == 0) begin
                    errors++;
                    $display("FAIL addr_unexpected: got %h want none", mem_bus.addr);
                end else begin
                    ea = exp_addr.pop_front();
                    if (mem_bus.addr !== ea) begin
                        errors++;
                        $display("FAIL addr_order: got %h want %h", mem_bus.addr, ea);
                    end
                end
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
            gap_cnt = (busy && !win_valid) ? gap_cnt + 1 : 0;
            if (spur) begin
                rdy = 1'b1;
                rd = 32'hDEADBEEF;
            end
        end
        mem_bus.ready = rdy;
        mem_bus.rdata = rd;
        prev_sel = mem_bus.sel;
        prev_rdy = rdy;
        prev_addr = mem_bus.addr;
        if (win_valid && win_ready) begin
            win_cnt++;
            vectors++;
            if (exp_win.size() == 0) begin
                errors++;
                $display("FAIL win_unexpected: got (%0d,%0d) want none", win_row, win_col);
            end else begin
                ew = exp_win.pop_front();
                if (win_data !== ew.data || win_row !== ew.row || win_col !== ew.col) begin
                    errors++;
                    $display("FAIL win: got (%0d,%0d) %h want (%0d,%0d) %h",
                             win_row, win_col, win_data, ew.row, ew.col, ew.data);
                end
            end
        end
        if (done) done_cnt++;
    end

    task automatic push_scan(input logic [AW-1:0] b, input logic [7:0] w, input logic [7:0] h);
        win_t e;
        logic [AW-1:0] a;
        if (w < K || h < K) return;
        for (int r = 0; r <= int'(h) - K; r++) begin
            for (int c = 0; c <= int'(w) - K; c++) begin
                e.data = '0;
                e.row = 8'(r);
                e.col = 8'(c);
                for (int kr = 0; kr < K; kr++) begin
                    for (int kc = 0; kc < K; kc++) begin
                        a = 16'(int'(b) + (r + kr) * int'(w) + c + kc);
                        exp_addr.push_back(a);
                        e.data[(kr*K+kc)*DW +: DW] = pix(a);
                    end
                end
                exp_win.push_back(e);
            end
        end
    endtask

    // returns at the falling edge after start was sampled; inputs are scrambled to prove they were latched
    task automatic kick(input logic [AW-1:0] b, input logic [7:0] w, input logic [7:0] h);
        @(negedge clk);
        base_addr = b;
        img_w = w;
        img_h = h;
        obs_addr.delete();
        win_cnt = 0;
        push_scan(b, w, h);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        base_addr = ~b;
        img_w = 8'd1;
        img_h = 8'd1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt - d0);
        end
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_after: got %b want 0", name, busy);
        end
        vectors++;
        if (exp_win.size() != 0 || exp_addr.size() != 0) begin
            errors++;
            $display("FAIL %s leftover: got %0d windows %0d addrs want 0 0", name, exp_win.size(), exp_addr.size());
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, mem_bus.sel, mem_bus.w, win_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000", {busy, done, mem_bus.sel, mem_bus.w, win_valid});
        end
        vectors++;
        if (mem_bus.addr !== '0 || win_row !== '0 || win_col !== '0) begin
            errors++;
            $display("FAIL reset_pos: got %h %0d %0d want 0 0 0", mem_bus.addr, win_row, win_col);
        end
        vectors++;
        if (win_data !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", win_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [AW-1:0] want [9];
        want = '{16'h100, 16'h101, 16'h102, 16'h104, 16'h105, 16'h106, 16'h108, 16'h109, 16'h10A};
        lat = 0;
        kick(16'h0100, 8'd4, 8'd4);
        wait_done("basic");
        for (int i = 0; i < 9; i++) begin
            vectors++;
            if (obs_addr.size() <= i || obs_addr[i] !== want[i]) begin
                errors++;
                $display("FAIL basic_addr%0d: got %h want %h", i, obs_addr.size() > i ? obs_addr[i] : 16'hxxxx, want[i]);
            end
        end
        vectors++;
        if (win_cnt != 4) begin
            errors++;
            $display("FAIL basic_windows: got %0d want 4", win_cnt);
        end
    endtask

    task automatic test_ready_delay;
        logic [AW-1:0] a0;
        lat = 3;
        kick(16'h0200, 8'd4, 8'd4);
        #2;
        a0 = mem_bus.addr;
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (mem_bus.sel !== (i != 4) || mem_bus.ready !== (i == 3) || (i < 4 && mem_bus.addr !== a0)) begin
                errors++;
                $display("FAIL delay_c%0d: got sel %b rdy %b addr %h want sel %b rdy %b addr %h",
                         i, mem_bus.sel, mem_bus.ready, mem_bus.addr, i != 4, i == 3, a0);
            end
            @(negedge clk);
            #2;
        end
        wait_done("delay");
    endtask

    task automatic test_stall;
        logic [NW*DW-1:0] d;
        int n = 0;
        lat = 0;
        win_ready = 1'b0;
        kick(16'h0300, 8'd4, 8'd3);
        while (!win_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!win_valid) begin
            errors++;
            $display("FAIL stall_timeout: got win_valid %b want 1", win_valid);
        end
        d = win_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (win_valid !== 1'b1 || win_data !== d || mem_bus.sel !== 1'b0) begin
                errors++;
                $display("FAIL stall_c%0d: got valid %b sel %b data %h want 1 0 %h", i, win_valid, mem_bus.sel, win_data, d);
            end
        end
        win_ready = 1'b1;
        wait_done("stall");
    endtask

    task automatic test_small;
        int s0 = sel_cnt;
        kick(16'h0000, 8'd2, 8'd5);
        vectors++;
        if (busy !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL small_done: got busy %b done %b want 1 1", busy, done);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL small_idle: got busy %b done %b want 0 0", busy, done);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (sel_cnt != s0) begin
            errors++;
            $display("FAIL small_sel: got %0d requests want 0", sel_cnt - s0);
        end
    endtask

    task automatic test_wrap;
        lat = 1;
        kick(16'hFFFE, 8'd3, 8'd3);
        wait_done("wrap");
        vectors++;
        if (obs_addr.size() != 9 || obs_addr[0] !== 16'hFFFE || obs_addr[2] !== 16'h0000 || obs_addr[3] !== 16'h0001) begin
            errors++;
            $display("FAIL wrap_addr: got %0d reqs first %h third %h want 9 fffe 0000", obs_addr.size(),
                     obs_addr.size() > 0 ? obs_addr[0] : 16'hxxxx, obs_addr.size() > 2 ? obs_addr[2] : 16'hxxxx);
        end
        vectors++;
        if (win_cnt != 1) begin
            errors++;
            $display("FAIL wrap_windows: got %0d want 1", win_cnt);
        end
    endtask

    task automatic test_spurious;
        lat = 1;
        spur = 1'b1;
        kick(16'h0400, 8'd5, 8'd4);
        wait_done("spurious");
        spur = 1'b0;
        vectors++;
        if (win_cnt != 6) begin
            errors++;
            $display("FAIL spurious_windows: got %0d want 6", win_cnt);
        end
    endtask

    task automatic test_reset_mid;
        int n = 0;
        lat = 2;
        kick(16'h0500, 8'd4, 8'd4);
        while ((obs_addr.size() < 4 || !mem_bus.sel) && n < 500) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!mem_bus.sel) begin
            errors++;
            $display("FAIL midrst_timeout: got sel %b want 1", mem_bus.sel);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({busy, done, mem_bus.sel, mem_bus.w, win_valid} !== 5'b0 || mem_bus.addr !== '0) begin
            errors++;
            $display("FAIL midrst_ctrl: got %b addr %h want 00000 0000",
                     {busy, done, mem_bus.sel, mem_bus.w, win_valid}, mem_bus.addr);
        end
        vectors++;
        if (win_data !== '0 || win_row !== '0 || win_col !== '0) begin
            errors++;
            $display("FAIL midrst_win: got (%0d,%0d) %h want (0,0) 0", win_row, win_col, win_data);
        end
        rst = 1'b0;
        exp_win.delete();
        exp_addr.delete();
        lat = 0;
        kick(16'h0600, 8'd3, 8'd4);
        wait_done("midrst_rescan");
        vectors++;
        if (win_cnt != 2) begin
            errors++;
            $display("FAIL midrst_windows: got %0d want 2", win_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ready_delay();
        test_stall();
        test_small();
        test_wrap();
        test_spurious();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
